// File: rtl/nn_pkg.sv
// Shared layer constants and the streamer FSM state encoding.
package nn_pkg;

    localparam int NUM_NEURONS = 28;
    localparam int ACC_W       = 18;
    localparam int OUT_W       = 8;
    localparam int IDX_W       = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/act_quant.sv
// Combinational activation: bias-add, ReLU, round-half-up right shift, saturate to OUT_W.
module act_quant
    import nn_pkg::*;
#(
    parameter int SHIFT = 6
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [ACC_W-1:0] bias,
    output logic        [OUT_W-1:0] act
);

    // Two extra bits so the rounding increment cannot wrap a maximal positive sum.
    localparam logic [ACC_W+1:0] HALF = {{(ACC_W+1){1'b0}}, 1'b1} << (SHIFT-1);

    logic signed [ACC_W:0]   sum;
    logic        [ACC_W+1:0] rnd;
    logic        [ACC_W+1:0] r;

    always_comb begin
        sum = {acc[ACC_W-1], acc} + {bias[ACC_W-1], bias};
        rnd = {1'b0, sum} + HALF;
        r   = rnd >> SHIFT;
        if (sum[ACC_W] || sum == '0) begin
            act = '0;
        end else if (|r[ACC_W+1:OUT_W]) begin
            act = '1;
        end else begin
            act = r[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/layer1_act_streamer.sv
// Captures a frame of layer-1 MAC results and streams quantised activations
// one per cycle over a valid/ready interface.
//
//   state  | meaning
//   IDLE   | waiting for acc_valid; acc_ready high
//   LOAD   | bank captured; element 0 registered on exit
//   STREAM | presenting act_index; advance on valid && ready
module layer1_act_streamer
    import nn_pkg::*;
#(
    parameter int SHIFT = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_NEURONS*ACC_W-1:0] acc_flat,
    input  logic [NUM_NEURONS*ACC_W-1:0] bias_flat,
    input  logic                         acc_valid,
    output logic                         acc_ready,
    output logic [OUT_W-1:0]             act_data,
    output logic [IDX_W-1:0]             act_index,
    output logic                         act_last,
    output logic                         act_valid,
    input  logic                         act_ready,
    output logic                         overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t            state;
    logic [ACC_W-1:0]  acc_bank  [NUM_NEURONS];
    logic [ACC_W-1:0]  bias_bank [NUM_NEURONS];
    logic [IDX_W-1:0]  sel;
    logic [OUT_W-1:0]  act_next;

    assign acc_ready = (state == IDLE);

    // act_index doubles as the frame counter; sel points at the element registered next.
    always_comb begin
        sel = '0;
        if (state == STREAM && act_index != LAST_IDX) begin
            sel = act_index + 1'b1;
        end
    end

    act_quant #(
        .SHIFT (SHIFT)
    ) u_act_quant (
        .acc  (acc_bank[sel]),
        .bias (bias_bank[sel]),
        .act  (act_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            act_data  <= '0;
            act_index <= '0;
            act_last  <= 1'b0;
            act_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                acc_bank[i]  <= '0;
                bias_bank[i] <= '0;
            end
        end else begin
            if (acc_valid && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (acc_valid) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            acc_bank[i]  <= acc_flat[i*ACC_W +: ACC_W];
                            bias_bank[i] <= bias_flat[i*ACC_W +: ACC_W];
                        end
                        act_index <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    act_data  <= act_next;
                    act_index <= '0;
                    act_last  <= (LAST_IDX == '0);
                    act_valid <= 1'b1;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (act_valid && act_ready) begin
                        if (act_index == LAST_IDX) begin
                            act_valid <= 1'b0;
                            act_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            act_data  <= act_next;
                            act_index <= act_index + 1'b1;
                            act_last  <= (act_index + 1'b1 == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer1_act_streamer.sv
// Randomised self-checking bench for layer1_act_streamer against an arithmetic reference.
module tb_layer1_act_streamer;
    import nn_pkg::*;

    localparam int SHIFT = 6;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [NUM_NEURONS*ACC_W-1:0] acc_flat;
    logic [NUM_NEURONS*ACC_W-1:0] bias_flat;
    logic                         acc_valid;
    logic                         acc_ready;
    logic [OUT_W-1:0]             act_data;
    logic [IDX_W-1:0]             act_index;
    logic                         act_last;
    logic                         act_valid;
    logic                         act_ready;
    logic                         overrun;

    int n_cmp = 0;
    int n_err = 0;
    int acc_v   [NUM_NEURONS];
    int bias_v  [NUM_NEURONS];
    int exp_act [NUM_NEURONS];

    layer1_act_streamer #(.SHIFT(SHIFT)) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_flat  (acc_flat),
        .bias_flat (bias_flat),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .act_data  (act_data),
        .act_index (act_index),
        .act_last  (act_last),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer sum, ReLU, round half up via division, clamp.
    function automatic int model_act(int a, int b);
        int s;
        int r;
        s = a + b;
        if (s <= 0) return 0;
        r = (s + (1 << (SHIFT - 1))) / (1 << SHIFT);
        if (r > (1 << OUT_W) - 1) return (1 << OUT_W) - 1;
        return r;
    endfunction

    function automatic int rnd_word();
        case ($urandom_range(2))
            0:       return int'($urandom_range(262143)) - 131072;
            1:       return int'($urandom_range(4000)) - 2000;
            default: return int'($urandom_range(17000)) - 500;
        endcase
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < NUM_NEURONS; i++) begin
            acc_flat[i*ACC_W +: ACC_W]  = ACC_W'($urandom);
            bias_flat[i*ACC_W +: ACC_W] = ACC_W'($urandom);
        end
    endtask

    task automatic randomize_frame(input bit zero_bias);
        for (int i = 0; i < NUM_NEURONS; i++) begin
            acc_v[i]  = rnd_word();
            bias_v[i] = zero_bias ? 0 : rnd_word();
        end
    endtask

    task automatic start_frame();
        for (int i = 0; i < NUM_NEURONS; i++) begin
            acc_flat[i*ACC_W +: ACC_W]  = ACC_W'(acc_v[i]);
            bias_flat[i*ACC_W +: ACC_W] = ACC_W'(bias_v[i]);
            exp_act[i] = model_act(acc_v[i], bias_v[i]);
        end
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        scramble_inputs();
        check("load_valid", act_valid, 0);
        check("load_acc_ready", acc_ready, 0);
        tick();
        check("first_valid", act_valid, 1);
        check("first_index", act_index, 0);
    endtask

    task automatic stream(input int ready_pct, input int stall_idx, input int ovr_idx,
                          input int rst_idx, output int n_acc, output int cycles);
        bit stall_done = 1'b0;
        bit ovr_done   = 1'b0;
        bit chk_next   = 1'b0;
        int nxt        = 0;
        n_acc  = 0;
        cycles = 0;
        while (n_acc < NUM_NEURONS && cycles < 400) begin
            if (chk_next) begin
                check("after_stall_index", act_index, nxt);
                check("after_stall_valid", act_valid, 1);
                chk_next = 1'b0;
            end
            if (act_valid && rst_idx >= 0 && int'(act_index) == rst_idx) begin
                reset = 1'b0;
                #1;
                check("rst_act_valid", act_valid, 0);
                check("rst_act_index", act_index, 0);
                check("rst_acc_ready", acc_ready, 1);
                @(negedge clk);
                reset = 1'b1;
                tick();
                return;
            end
            if (act_valid && ovr_idx >= 0 && int'(act_index) == ovr_idx && !ovr_done) begin
                act_ready = 1'b0;
                scramble_inputs();
                acc_valid = 1'b1;
                tick();
                cycles++;
                acc_valid = 1'b0;
                ovr_done  = 1'b1;
                check("ovr_flag", overrun, 1);
                check("ovr_index_held", act_index, ovr_idx);
                continue;
            end
            if (act_valid && int'(act_index) == stall_idx && !stall_done) begin
                act_ready = 1'b0;
                repeat (5) begin
                    tick();
                    cycles++;
                    check("stall_data", act_data, exp_act[n_acc]);
                    check("stall_index", act_index, n_acc);
                    check("stall_valid", act_valid, 1);
                end
                stall_done = 1'b1;
                act_ready  = 1'b1;
                chk_next   = 1'b1;
                nxt        = stall_idx + 1;
            end else begin
                act_ready = ($urandom_range(99) < ready_pct);
            end
            if (act_valid && act_ready) begin
                check("data", act_data, exp_act[n_acc]);
                check("index", act_index, n_acc);
                check("last", act_last, (n_acc == NUM_NEURONS - 1) ? 1 : 0);
                n_acc++;
            end
            tick();
            cycles++;
        end
        if (n_acc < NUM_NEURONS) check("timeout_accepts", n_acc, NUM_NEURONS);
    endtask

    task automatic check_end();
        check("end_valid", act_valid, 0);
        check("end_last", act_last, 0);
        check("end_acc_ready", acc_ready, 1);
    endtask

    int n;
    int c;

    initial begin
        reset     = 1'b0;
        acc_valid = 1'b0;
        act_ready = 1'b1;
        acc_flat  = '0;
        bias_flat = '0;
        scramble_inputs();

        // Reset held with acc_valid toggling
        for (int i = 0; i < 4; i++) begin
            acc_valid = ~acc_valid;
            tick();
            check("rst_acc_ready", acc_ready, 1);
            check("rst_valid", act_valid, 0);
            check("rst_data", act_data, 0);
            check("rst_index", act_index, 0);
            check("rst_last", act_last, 0);
            check("rst_overrun", overrun, 0);
        end
        acc_valid = 1'b0;
        reset     = 1'b1;
        tick();
        check("post_rst_acc_ready", acc_ready, 1);
        check("post_rst_valid", act_valid, 0);

        // Basic frame, zero biases
        randomize_frame(1'b1);
        acc_v[0]  = 640;
        acc_v[1]  = -100;
        acc_v[27] = 100000;
        start_frame();
        check("basic_exp0", act_data, 10);
        stream(100, -1, -1, -1, n, c);
        check("basic_cycles", c, NUM_NEURONS);
        check_end();

        // Rounding, bias and range extremes
        randomize_frame(1'b0);
        acc_v[0] = 95;      bias_v[0] = 0;
        acc_v[1] = 96;      bias_v[1] = 0;
        acc_v[2] = -50;     bias_v[2] = 114;
        acc_v[3] = 30;      bias_v[3] = -31;
        acc_v[4] = 131071;  bias_v[4] = 131071;
        acc_v[5] = -131072; bias_v[5] = -131072;
        acc_v[6] = 16351;   bias_v[6] = 0;
        acc_v[7] = 16352;   bias_v[7] = 0;
        start_frame();
        stream(100, -1, -1, -1, n, c);
        check_end();

        // Backpressure at index 3
        randomize_frame(1'b0);
        start_frame();
        stream(100, 3, -1, -1, n, c);
        check("stall_accepts", n, NUM_NEURONS);
        check_end();

        // Random backpressure over several frames
        repeat (3) begin
            randomize_frame(1'b0);
            start_frame();
            stream(60, -1, -1, -1, n, c);
            check_end();
        end

        // Overrun pulse during stream
        randomize_frame(1'b0);
        start_frame();
        stream(100, -1, 12, -1, n, c);
        check_end();
        repeat (3) begin
            tick();
            check("no_second_frame", act_valid, 0);
        end
        check("overrun_sticky", overrun, 1);

        // Reset mid-stream, then a clean frame
        randomize_frame(1'b0);
        start_frame();
        stream(100, -1, -1, 10, n, c);
        check("rst_partial_accepts", n, 10);
        check("rst_clr_overrun", overrun, 0);
        check("rst_after_valid", act_valid, 0);
        check("rst_after_ready", acc_ready, 1);
        randomize_frame(1'b0);
        start_frame();
        stream(100, -1, -1, -1, n, c);
        check("post_rst_cycles", c, NUM_NEURONS);
        check_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
